// File: rtl/anita3_trig_pkg.sv
`default_nettype none
// ============================================================================
//  Module : anita3_trig_pkg
//  Brief  : Shared sizes, trigger-source bit positions and the scheduler
//           state encoding for the ANITA3 hold scheduler.
//  Rev    : 1.0  initial release
// ============================================================================
package anita3_trig_pkg;

   // Trigger source count and bit positions inside the trigger vector.
   localparam int NUM_TRIG  = 4;
   localparam int TRIG_RF   = 0;
   localparam int TRIG_PPS1 = 1;
   localparam int TRIG_PPS2 = 2;
   localparam int TRIG_SOFT = 3;

   // SURF hold buffer count (power of two) and its index width.
   localparam int NUM_HOLD  = 4;
   localparam int BUF_BITS  = $clog2(NUM_HOLD);

   // Scheduler states.
   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_ISSUE   = 2'd1,
      S_HOLDOFF = 2'd2
   } sched_state_e;

endpackage : anita3_trig_pkg
`default_nettype wire

// File: rtl/anita3_trig_edge_detect.sv
`default_nettype none
// ============================================================================
//  Module : anita3_trig_edge_detect
//  Brief  : Registered rising-edge detector for the trigger level inputs.
//           The edge vector is presented one cycle after the input is
//           first sampled high, giving the scheduler a clean registered
//           source mask.
//  Rev    : 1.0  initial release
// ============================================================================
module anita3_trig_edge_detect #(
   parameter int WIDTH = 4
) (
   input  logic             clk_i,
   input  logic             rst_n_i,
   input  logic [WIDTH-1:0] trig_i,
   output logic [WIDTH-1:0] edge_o
);

   logic [WIDTH-1:0] trig_q;
   logic [WIDTH-1:0] edge_q;

   // Track previous trigger levels and register the rising-edge vector.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         trig_q <= '0;
         edge_q <= '0;
      end else begin
         trig_q <= trig_i;
         edge_q <= trig_i & ~trig_q;
      end
   end

   assign edge_o = edge_q;

endmodule : anita3_trig_edge_detect
`default_nettype wire

// File: rtl/anita3_hold_scheduler.sv
`default_nettype none
// ============================================================================
//  Module : anita3_hold_scheduler
//  Brief  : Allocates SURF hold buffers in strict round-robin order to
//           incoming trigger edges, issues digitize requests, releases
//           buffers on readout clears, flags deadtime and counts lost
//           triggers. Single clk250 domain.
//  Rev    : 1.0  initial release
// ============================================================================
module anita3_hold_scheduler #(
   parameter int NUM_TRIG = anita3_trig_pkg::NUM_TRIG,
   parameter int NUM_HOLD = anita3_trig_pkg::NUM_HOLD,
   parameter int HOLDOFF  = 16
) (
   input  logic                        clk250_i,
   input  logic                        rst_n_i,
   input  logic [NUM_TRIG-1:0]         trig_i,
   input  logic                        disable_i,
   input  logic                        clear_i,
   input  logic [$clog2(NUM_HOLD)-1:0] clear_buffer_i,
   output logic                        digitize_o,
   output logic [$clog2(NUM_HOLD)-1:0] digitize_buffer_o,
   output logic [NUM_TRIG-1:0]         digitize_source_o,
   input  logic                        digitize_ack_i,
   output logic [NUM_HOLD-1:0]         HOLD_o,
   output logic [NUM_HOLD-1:0]         buffer_status_o,
   output logic                        dead_o,
   output logic [15:0]                 lost_count_o
);

   import anita3_trig_pkg::*;

   localparam int BUF_BITS = $clog2(NUM_HOLD);
   // Holdoff counter only needs to reach HOLDOFF-1.
   localparam int CNT_W    = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;

   sched_state_e          state_q;
   logic [BUF_BITS-1:0]   wr_ptr_q;
   logic [CNT_W-1:0]      cnt_q;
   logic                  digitize_q;
   logic [BUF_BITS-1:0]   dig_buf_q;
   logic [NUM_TRIG-1:0]   dig_src_q;
   logic [NUM_HOLD-1:0]   status_q;
   logic [NUM_HOLD-1:0]   hold_q;
   logic [NUM_HOLD-1:0]   hold_d;
   logic [15:0]           lost_q;

   logic [NUM_TRIG-1:0]   edge_w;
   logic                  any_edge_w;
   logic                  accept_w;
   logic                  lost_w;

   anita3_trig_edge_detect #(
      .WIDTH (NUM_TRIG)
   ) u_edge (
      .clk_i   (clk250_i),
      .rst_n_i (rst_n_i),
      .trig_i  (trig_i),
      .edge_o  (edge_w)
   );

   // Accept only into the buffer at the write pointer; a full slot there
   // blocks the scheduler even when other buffers are free.
   assign any_edge_w = |edge_w;
   assign accept_w   = any_edge_w & (state_q == S_IDLE) & ~disable_i & ~hold_q[wr_ptr_q];
   assign lost_w     = any_edge_w & ~disable_i & ~accept_w;

   // Next hold vector: clear releases first, accept then claims the slot.
   // Accept never targets an occupied slot, so a same-cycle clear of the
   // write-pointer buffer cannot be bypassed by a trigger.
   always_comb begin
      hold_d = hold_q;
      if (clear_i) begin
         hold_d[clear_buffer_i] = 1'b0;
      end
      if (accept_w) begin
         hold_d[wr_ptr_q] = 1'b1;
      end
   end

   // Hold buffer occupancy register.
   always_ff @(posedge clk250_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         hold_q <= '0;
      end else begin
         hold_q <= hold_d;
      end
   end

   // Scheduler FSM with registered digitize command and write pointer.
   always_ff @(posedge clk250_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q    <= S_IDLE;
         wr_ptr_q   <= '0;
         cnt_q      <= '0;
         digitize_q <= 1'b0;
         dig_buf_q  <= '0;
         dig_src_q  <= '0;
         status_q   <= '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (accept_w) begin
                  digitize_q <= 1'b1;
                  dig_buf_q  <= wr_ptr_q;
                  dig_src_q  <= edge_w;
                  status_q   <= hold_d;
                  wr_ptr_q   <= wr_ptr_q + 1'b1;
                  state_q    <= S_ISSUE;
               end
            end
            S_ISSUE: begin
               if (digitize_ack_i) begin
                  digitize_q <= 1'b0;
                  if (HOLDOFF == 0) begin
                     state_q <= S_IDLE;
                  end else begin
                     cnt_q   <= CNT_W'(HOLDOFF - 1);
                     state_q <= S_HOLDOFF;
                  end
               end
            end
            S_HOLDOFF: begin
               if (cnt_q == '0) begin
                  state_q <= S_IDLE;
               end else begin
                  cnt_q <= cnt_q - 1'b1;
               end
            end
            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   // Saturating count of enabled trigger edges that could not be accepted.
   always_ff @(posedge clk250_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         lost_q <= '0;
      end else if (lost_w && (lost_q != 16'hFFFF)) begin
         lost_q <= lost_q + 16'd1;
      end
   end

   assign digitize_o        = digitize_q;
   assign digitize_buffer_o = dig_buf_q;
   assign digitize_source_o = dig_src_q;
   assign HOLD_o            = hold_q;
   assign buffer_status_o   = status_q;
   assign lost_count_o      = lost_q;
   assign dead_o            = disable_i | (state_q != S_IDLE) | hold_q[wr_ptr_q];

endmodule : anita3_hold_scheduler
`default_nettype wire

// File: tb/tb_anita3_hold_scheduler.sv
`default_nettype none
// ============================================================================
//  Module : tb_anita3_hold_scheduler
//  Brief  : Self-checking bench for anita3_hold_scheduler: hand-timed
//           latency/holdoff/reset sequence, then a table of directed
//           vectors covering allocation order, full/lost, clears and
//           disable.
//  Rev    : 1.0  initial release
// ============================================================================
module tb_anita3_hold_scheduler;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [3:0]  trig;
   logic        dis;
   logic        clr;
   logic [1:0]  cbuf;
   logic        ack;
   logic        dig;
   logic [1:0]  dbuf;
   logic [3:0]  dsrc;
   logic [3:0]  hold;
   logic [3:0]  stat;
   logic        dead;
   logic [15:0] lost;

   int checks   = 0;
   int failures = 0;
   int ec       = 0;

   always #5 clk = ~clk;

   // Posedge counter, restarted by reset, used to place hand-timed stimulus.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) ec <= 0;
      else        ec <= ec + 1;
   end

   anita3_hold_scheduler #(
      .NUM_TRIG (4),
      .NUM_HOLD (4),
      .HOLDOFF  (16)
   ) dut (
      .clk250_i          (clk),
      .rst_n_i           (rst_n),
      .trig_i            (trig),
      .disable_i         (dis),
      .clear_i           (clr),
      .clear_buffer_i    (cbuf),
      .digitize_o        (dig),
      .digitize_buffer_o (dbuf),
      .digitize_source_o (dsrc),
      .digitize_ack_i    (ack),
      .HOLD_o            (hold),
      .buffer_status_o   (stat),
      .dead_o            (dead),
      .lost_count_o      (lost)
   );

   typedef struct {
      int          n;
      logic [3:0]  trig;
      logic        dis;
      logic        clr;
      logic [1:0]  cbuf;
      logic        ack;
      logic [3:0]  e_hold;
      logic        e_dig;
      logic [1:0]  e_dbuf;
      logic [3:0]  e_dsrc;
      logic [3:0]  e_stat;
      logic        e_dead;
      logic [15:0] e_lost;
   } vec_t;

   vec_t tv[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic add(input int n, input logic [3:0] t, input logic d, input logic c,
                      input logic [1:0] cb, input logic a, input logic [3:0] eh,
                      input logic edg, input logic [1:0] edb, input logic [3:0] eds,
                      input logic [3:0] est, input logic edd, input logic [15:0] el);
      vec_t v;
      v.n = n; v.trig = t; v.dis = d; v.clr = c; v.cbuf = cb; v.ack = a;
      v.e_hold = eh; v.e_dig = edg; v.e_dbuf = edb; v.e_dsrc = eds;
      v.e_stat = est; v.e_dead = edd; v.e_lost = el;
      tv.push_back(v);
   endtask

   // Wait (at a negedge) until posedge number n has happened since reset.
   task automatic goto(input int n);
      int guard = 0;
      while (ec < n && guard < 200) begin
         @(negedge clk);
         guard++;
      end
      if (ec != n) begin
         failures++;
         $display("FAIL goto: edge count %0d expected %0d", ec, n);
      end
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_hold"}, 32'(hold), 32'h0);
      chk({tag, "_dig"},  32'(dig),  32'h0);
      chk({tag, "_dbuf"}, 32'(dbuf), 32'h0);
      chk({tag, "_dsrc"}, 32'(dsrc), 32'h0);
      chk({tag, "_stat"}, 32'(stat), 32'h0);
      chk({tag, "_dead"}, 32'(dead), 32'h0);
      chk({tag, "_lost"}, 32'(lost), 32'h0);
   endtask

   initial begin
      rst_n = 1'b0; trig = '0; dis = 1'b0; clr = 1'b0; cbuf = '0; ack = 1'b0;
      repeat (2) @(negedge clk);
      chk_all_zero("reset");
      rst_n = 1'b1;

      // ---- Latency, holdoff length and edge-in-ISSUE loss ----
      goto(9);  trig = 4'b0001;
      goto(10); trig = 4'b0000;
      chk("t1_hold_e10", 32'(hold), 32'h0);
      chk("t1_dig_e10",  32'(dig),  32'h0);
      goto(11);
      chk("t1_hold_e11", 32'(hold), 32'h1);
      chk("t1_dig_e11",  32'(dig),  32'h1);
      chk("t1_dbuf_e11", 32'(dbuf), 32'h0);
      chk("t1_dsrc_e11", 32'(dsrc), 32'h1);
      chk("t1_stat_e11", 32'(stat), 32'h1);
      chk("t1_dead_e11", 32'(dead), 32'h1);
      trig = 4'b0100;                      // sampled at 12 while in ISSUE
      goto(12); trig = 4'b0000;
      goto(13);
      chk("t1_lost_issue", 32'(lost), 32'h1);
      goto(14); ack = 1'b1;
      chk("t1_dig_e14", 32'(dig), 32'h1);
      goto(15); ack = 1'b0;
      chk("t1_dig_e15",  32'(dig),  32'h0);
      chk("t1_dead_e15", 32'(dead), 32'h1);
      goto(30);
      chk("t1_dead_e30", 32'(dead), 32'h1);
      goto(31);
      chk("t1_dead_e31", 32'(dead), 32'h0);

      // ---- Reset while a request is outstanding ----
      goto(31); trig = 4'b0010;
      goto(32); trig = 4'b0000;
      goto(33);
      chk("rst_pre_dig",  32'(dig),  32'h1);
      chk("rst_pre_hold", 32'(hold), 32'h3);
      rst_n = 1'b0;
      #1;
      chk_all_zero("rst_issue");
      @(negedge clk);
      rst_n = 1'b1;

      // ---- Table: {n, trig, dis, clr, cbuf, ack | hold, dig, dbuf, dsrc, stat, dead, lost}
      add(1, 4'b1001,0,0,0,0, 4'b0000,0,0,4'b0000,4'b0000,0,0);
      add(1, 4'b0000,0,0,0,0, 4'b0001,1,0,4'b1001,4'b0001,1,0);
      add(1, 4'b0000,0,0,0,1, 4'b0001,0,0,4'b1001,4'b0001,1,0);
      add(15,4'b0000,0,0,0,0, 4'b0001,0,0,4'b1001,4'b0001,1,0);
      add(1, 4'b0000,0,0,0,0, 4'b0001,0,0,4'b1001,4'b0001,0,0);
      add(1, 4'b0010,0,0,0,0, 4'b0001,0,0,4'b1001,4'b0001,0,0);
      add(1, 4'b0000,0,0,0,0, 4'b0011,1,1,4'b0010,4'b0011,1,0);
      add(1, 4'b0000,0,0,0,1, 4'b0011,0,1,4'b0010,4'b0011,1,0);
      add(16,4'b0000,0,0,0,0, 4'b0011,0,1,4'b0010,4'b0011,0,0);
      add(1, 4'b0100,0,0,0,0, 4'b0011,0,1,4'b0010,4'b0011,0,0);
      add(1, 4'b0000,0,0,0,0, 4'b0111,1,2,4'b0100,4'b0111,1,0);
      add(1, 4'b0000,0,0,0,1, 4'b0111,0,2,4'b0100,4'b0111,1,0);
      add(16,4'b0000,0,0,0,0, 4'b0111,0,2,4'b0100,4'b0111,0,0);
      add(1, 4'b0001,0,0,0,0, 4'b0111,0,2,4'b0100,4'b0111,0,0);
      add(1, 4'b0000,0,0,0,0, 4'b1111,1,3,4'b0001,4'b1111,1,0);
      add(1, 4'b0000,0,0,0,1, 4'b1111,0,3,4'b0001,4'b1111,1,0);
      add(16,4'b0000,0,0,0,0, 4'b1111,0,3,4'b0001,4'b1111,1,0);
      // all full: fifth trigger lost
      add(1, 4'b0001,0,0,0,0, 4'b1111,0,3,4'b0001,4'b1111,1,0);
      add(1, 4'b0000,0,0,0,0, 4'b1111,0,3,4'b0001,4'b1111,1,1);
      // clear buffer 2 only: pointer slot 0 still full
      add(1, 4'b0000,0,1,2,0, 4'b1011,0,3,4'b0001,4'b1111,1,1);
      add(1, 4'b0001,0,0,0,0, 4'b1011,0,3,4'b0001,4'b1111,1,1);
      add(1, 4'b0000,0,0,0,0, 4'b1011,0,3,4'b0001,4'b1111,1,2);
      // clear buffer 0: next trigger lands in buffer 0
      add(1, 4'b0000,0,1,0,0, 4'b1010,0,3,4'b0001,4'b1111,0,2);
      add(1, 4'b1000,0,0,0,0, 4'b1010,0,3,4'b0001,4'b1111,0,2);
      add(1, 4'b0000,0,0,0,0, 4'b1011,1,0,4'b1000,4'b1011,1,2);
      add(1, 4'b0000,0,0,0,1, 4'b1011,0,0,4'b1000,4'b1011,1,2);
      add(16,4'b0000,0,0,0,0, 4'b1011,0,0,4'b1000,4'b1011,1,2);
      // edge and clear of the pointer slot together: lost, slot free after
      add(1, 4'b0001,0,0,0,0, 4'b1011,0,0,4'b1000,4'b1011,1,2);
      add(1, 4'b0000,0,1,1,0, 4'b1001,0,0,4'b1000,4'b1011,0,3);
      // disabled edges: no hold, not counted
      add(1, 4'b1111,1,0,0,0, 4'b1001,0,0,4'b1000,4'b1011,1,3);
      add(1, 4'b0000,1,0,0,0, 4'b1001,0,0,4'b1000,4'b1011,1,3);
      add(1, 4'b0000,0,0,0,0, 4'b1001,0,0,4'b1000,4'b1011,0,3);

      for (int i = 0; i < tv.size(); i++) begin
         trig = tv[i].trig; dis = tv[i].dis; clr = tv[i].clr;
         cbuf = tv[i].cbuf; ack = tv[i].ack;
         repeat (tv[i].n) @(negedge clk);
         chk($sformatf("v%0d_hold", i), 32'(hold), 32'(tv[i].e_hold));
         chk($sformatf("v%0d_dig",  i), 32'(dig),  32'(tv[i].e_dig));
         chk($sformatf("v%0d_dbuf", i), 32'(dbuf), 32'(tv[i].e_dbuf));
         chk($sformatf("v%0d_dsrc", i), 32'(dsrc), 32'(tv[i].e_dsrc));
         chk($sformatf("v%0d_stat", i), 32'(stat), 32'(tv[i].e_stat));
         chk($sformatf("v%0d_dead", i), 32'(dead), 32'(tv[i].e_dead));
         chk($sformatf("v%0d_lost", i), 32'(lost), 32'(tv[i].e_lost));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule : tb_anita3_hold_scheduler
`default_nettype wire
